// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel streaming engine.
package sobel_pkg;

  localparam int NUM_TAPS = 9;
  localparam int TAP_P0   = 0;
  localparam int TAP_P1   = 1;
  localparam int TAP_P2   = 2;
  localparam int TAP_P3   = 3;
  localparam int TAP_P4   = 4;
  localparam int TAP_P5   = 5;
  localparam int TAP_P6   = 6;
  localparam int TAP_P7   = 7;
  localparam int TAP_P8   = 8;

  function automatic int grad_w(input int pix_w);
    return pix_w + 32'sd3;
  endfunction

  function automatic logic [31:0] sat_mag(input logic [31:0] mag, input int pix_w);
    logic [31:0] lim;
    lim = (32'd1 << pix_w) - 32'd1;
    if (mag > lim) begin
      return lim;
    end else begin
      return mag;
    end
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / magnitude-out stream bundle; thresh exists only when SOBEL_THRESH_EN is defined.
interface sobel_stream_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [PIX_W-1:0] in_pix;
  logic             out_valid;
  logic             out_ready;
  logic             out_eol;
  logic [PIX_W-1:0] out_pix;
`ifdef SOBEL_THRESH_EN
  logic [PIX_W-1:0] thresh;

  modport slave (
    input  in_valid, in_sof, in_pix, out_ready, thresh,
    output in_ready, out_valid, out_eol, out_pix
  );
  modport master (
    output in_valid, in_sof, in_pix, out_ready, thresh,
    input  in_ready, out_valid, out_eol, out_pix
  );
`else
  modport slave (
    input  in_valid, in_sof, in_pix, out_ready,
    output in_ready, out_valid, out_eol, out_pix
  );
  modport master (
    output in_valid, in_sof, in_pix, out_ready,
    input  in_ready, out_valid, out_eol, out_pix
  );
`endif
endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of storage: combinational read of the addressed entry, write on the same clock edge.
module sobel_line_buffer #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int CNT_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CNT_W-1:0] addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [IMG_W];

  assign rd_data = mem[addr];

  // Contents are left unreset; they are only consumed once two rows are written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| engine: line buffers, window, two-stage gradient pipeline.
// Define SOBEL_THRESH_EN to emit a binary edge map against bus.thresh instead of the magnitude.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int CNT_W = $clog2(IMG_W)
) (
  input logic           clk,
  input logic           rst_n,
  sobel_stream_if.slave bus
);

  localparam int GRAD_W = grad_w(PIX_W);

  logic                     en;
  logic                     accept;
  logic [CNT_W-1:0]         col;
  logic [CNT_W-1:0]         cur_col;
  logic [1:0]               row;
  logic [1:0]               cur_row;
  logic                     last_col;
  logic                     win_ok;
  logic [PIX_W-1:0]         lb0_rd;
  logic [PIX_W-1:0]         lb1_rd;
  logic [PIX_W-1:0]         win_top [3];
  logic [PIX_W-1:0]         win_mid [3];
  logic [PIX_W-1:0]         win_bot [3];
  logic [PIX_W-1:0]         tap [NUM_TAPS];
  logic signed [GRAD_W-1:0] gx_next;
  logic signed [GRAD_W-1:0] gy_next;
  logic signed [GRAD_W-1:0] s1_gx;
  logic signed [GRAD_W-1:0] s1_gy;
  logic                     s1_valid;
  logic                     s1_eol;
  logic [GRAD_W-1:0]        abs_gx;
  logic [GRAD_W-1:0]        abs_gy;
  logic [GRAD_W-1:0]        mag;
  logic [PIX_W-1:0]         pix_next;

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed(GRAD_W'(p));
  endfunction

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign accept       = bus.in_valid && en;

  sobel_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .CNT_W(CNT_W)) u_lb0 (
    .clk(clk), .we(accept), .addr(cur_col), .wr_data(bus.in_pix), .rd_data(lb0_rd)
  );

  sobel_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .CNT_W(CNT_W)) u_lb1 (
    .clk(clk), .we(accept), .addr(cur_col), .wr_data(lb0_rd), .rd_data(lb1_rd)
  );

  // Position of the pixel on the bus; a start-of-frame overrides the running counters.
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (bus.in_sof) begin
      cur_col = '0;
      cur_row = 2'd0;
    end else begin
      cur_col = col;
      cur_row = row;
    end
    last_col = (cur_col == CNT_W'(IMG_W - 1));
    win_ok   = (cur_row == 2'd2) && (cur_col >= CNT_W'(2));
  end

  // Taps as they will be once the current pixel shifts in, so gradients register on acceptance.
  always_comb begin
    tap[TAP_P0] = win_top[1];
    tap[TAP_P1] = win_top[2];
    tap[TAP_P2] = lb1_rd;
    tap[TAP_P3] = win_mid[1];
    tap[TAP_P4] = win_mid[2];
    tap[TAP_P5] = lb0_rd;
    tap[TAP_P6] = win_bot[1];
    tap[TAP_P7] = win_bot[2];
    tap[TAP_P8] = bus.in_pix;
    gx_next = (ext(tap[TAP_P2]) + ext(tap[TAP_P5]) + ext(tap[TAP_P5]) + ext(tap[TAP_P8]))
            - (ext(tap[TAP_P0]) + ext(tap[TAP_P3]) + ext(tap[TAP_P3]) + ext(tap[TAP_P6]));
    gy_next = (ext(tap[TAP_P0]) + ext(tap[TAP_P1]) + ext(tap[TAP_P1]) + ext(tap[TAP_P2]))
            - (ext(tap[TAP_P6]) + ext(tap[TAP_P7]) + ext(tap[TAP_P7]) + ext(tap[TAP_P8]));
  end

  // Magnitude and output pixel formation for the second stage.
  always_comb begin
    pix_next = '0;
    if (s1_gx[GRAD_W-1]) begin
      abs_gx = $unsigned(-s1_gx);
    end else begin
      abs_gx = $unsigned(s1_gx);
    end
    if (s1_gy[GRAD_W-1]) begin
      abs_gy = $unsigned(-s1_gy);
    end else begin
      abs_gy = $unsigned(s1_gy);
    end
    mag = abs_gx + abs_gy;
`ifdef SOBEL_THRESH_EN
    if (mag >= GRAD_W'(bus.thresh)) begin
      pix_next = {PIX_W{1'b1}};
    end else begin
      pix_next = '0;
    end
`else
    pix_next = PIX_W'(sat_mag(32'(mag), PIX_W));
`endif
  end

  // Raster counters and window column shift registers, advanced per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        win_top[i] <= '0;
        win_mid[i] <= '0;
        win_bot[i] <= '0;
      end
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col <= cur_col + CNT_W'(1);
        row <= cur_row;
      end
      win_top[0] <= win_top[1];
      win_top[1] <= win_top[2];
      win_top[2] <= lb1_rd;
      win_mid[0] <= win_mid[1];
      win_mid[1] <= win_mid[2];
      win_mid[2] <= lb0_rd;
      win_bot[0] <= win_bot[1];
      win_bot[1] <= win_bot[2];
      win_bot[2] <= bus.in_pix;
    end
  end

  // Two-stage result pipeline; everything holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_eol        <= 1'b0;
      s1_gx         <= '0;
      s1_gy         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_eol   <= 1'b0;
      bus.out_pix   <= '0;
    end else if (en) begin
      s1_valid      <= accept && win_ok;
      s1_eol        <= accept && win_ok && last_col;
      s1_gx         <= gx_next;
      s1_gy         <= gy_next;
      bus.out_valid <= s1_valid;
      bus.out_eol   <= s1_eol;
      bus.out_pix   <= pix_next;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Randomized self-checking bench for sobel_stream against a frame-image reference model.
module tb_sobel_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int CNT_W = $clog2(IMG_W);
`ifdef SOBEL_THRESH_EN
  localparam int THRESH   = 128;
  localparam int EDGE_IN  = 40;
  localparam int EDGE_OUT = 255;
`else
  localparam int EDGE_IN  = 50;
  localparam int EDGE_OUT = 200;
`endif

  typedef struct {
    int pix;
    bit eol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sobel_stream_if #(.PIX_W(PIX_W)) bus ();

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef SOBEL_THRESH_EN
  assign bus.thresh = PIX_W'(THRESH);
`endif

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               img [3][IMG_W];
  int               m_row = 0;
  int               m_col = 0;
  int               n_vec = 0;
  int               n_bad = 0;
  int               n_out = 0;
  int               n_eol = 0;
  int               n_hi  = 0;
  int               n_sat = 0;
  bit               rand_ready = 1'b0;
  bit               hold_pending = 1'b0;
  logic [PIX_W-1:0] held_pix;
  logic             held_eol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: keep the last three image rows, emit a result whenever a full 3x3 neighbourhood exists.
  task automatic model_push(input int p, input bit sof);
    int w [3][3];
    int gx, gy, mag;
    exp_t e;
    if (sof) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row % 3][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          w[dr][dc] = img[(m_row - 2 + dr) % 3][m_col - 2 + dc];
      gx = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
      gy = (w[0][0] + 2 * w[0][1] + w[0][2]) - (w[2][0] + 2 * w[2][1] + w[2][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
      e.pix = (mag >= THRESH) ? 255 : 0;
`else
      e.pix = (mag > 255) ? 255 : mag;
`endif
      e.eol = (m_col == IMG_W - 1);
      exp_q.push_back(e);
    end
    if (m_col == IMG_W - 1) begin
      m_col = 0;
      m_row++;
    end else begin
      m_col++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
    else            bus.out_ready = 1'b1;
  end

  // Monitor: score outputs, verify held values across stalls, feed accepted pixels to the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_pix", 32'(bus.out_pix), 32'(held_pix));
        check("stall_eol", 32'(bus.out_eol), 32'(held_eol));
        hold_pending = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (bus.out_eol) n_eol++;
        if (bus.out_pix == PIX_W'(EDGE_OUT)) n_hi++;
        if (bus.out_pix == 8'd255) n_sat++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_pix", 32'(bus.out_pix), 32'(mon_e.pix));
          check("out_eol", 32'(bus.out_eol), 32'(mon_e.eol));
        end
      end else if (bus.out_valid) begin
        hold_pending = 1'b1;
        held_pix     = bus.out_pix;
        held_eol     = bus.out_eol;
      end
      if (bus.in_valid && bus.in_ready) model_push(int'(bus.in_pix), bus.in_sof);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input bit sof);
    int guard;
    bit acc;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_pix   = PIX_W'(p);
    bus.in_sof   = sof;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 1000) begin
        check("accept_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int rows, input bit with_sof, input bit bubbles);
    int p;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        case (kind)
          0:       p = 100;
          1:       p = (c >= 4) ? EDGE_IN : 0;
          2:       p = (r >= 2) ? 255 : 0;
          default: p = int'($urandom_range(0, 255));
        endcase
        if (bubbles && $urandom_range(0, 3) == 0) idle(1);
        send(p, with_sof && r == 0 && c == 0);
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      idle(1);
      g++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(4);
  endtask

  task automatic begin_test();
    n_out = 0;
    n_eol = 0;
    n_hi  = 0;
    n_sat = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pix   = '0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pix", 32'(bus.out_pix), 32'd0);
    check("rst_out_eol", 32'(bus.out_eol), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);

    begin_test();
    send_frame(0, 4, 1'b1, 1'b0);
    drain();
    check("const_count", 32'(n_out), 32'd12);
    check("const_eol", 32'(n_eol), 32'd2);

    begin_test();
    send_frame(1, 4, 1'b1, 1'b0);
    drain();
    check("vstep_count", 32'(n_out), 32'd12);
    check("vstep_edges", 32'(n_hi), 32'd4);

    begin_test();
    send_frame(2, 4, 1'b1, 1'b0);
    drain();
    check("hstep_sat", 32'(n_sat), 32'd12);

    begin_test();
    rand_ready = 1'b1;
    send_frame(3, 16, 1'b1, 1'b1);
    drain();
    rand_ready = 1'b0;
    idle(2);
    check("rand_count", 32'(n_out), 32'd84);

    begin_test();
    send_frame(3, 2, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) send(int'($urandom_range(0, 255)), 1'b0);
    send_frame(3, 2, 1'b1, 1'b0);
    idle(6);
    check("sof_hold", 32'(n_out), 32'd3);
    send_frame(3, 2, 1'b0, 1'b0);
    drain();
    check("sof_count", 32'(n_out), 32'd15);

    begin_test();
    send_frame(3, 3, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) send(int'($urandom_range(0, 255)), 1'b0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    hold_pending = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);
    begin_test();
    send_frame(3, 4, 1'b0, 1'b0);
    drain();
    check("post_rst_count", 32'(n_out), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
